// File: rtl/mul_pkg.sv
// mul_pkg: state encoding and counter sizing shared by the iterative multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int b_w);
        return $clog2(b_w + 1);
    endfunction

endpackage

// File: rtl/mul_addsub.sv
// mul_addsub: one accumulate step of the multiplier, adding or subtracting the partial product
module mul_addsub
    import mul_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] opnd,
    input  logic         sub,
    output logic [W-1:0] sum
);

    // subtract only on the signed MSB step, add otherwise
    always_comb sum = sub ? acc - opnd : acc + opnd;

endmodule

// File: rtl/mul_iter.sv
// mul_iter: shift-and-add multiplier, one multiplier bit per cycle; MUL_SIGNED_EN adds is_signed two's-complement mode
module mul_iter
    import mul_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 8
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     mul_a,
    input  logic [B_W-1:0]     mul_b,
`ifdef MUL_SIGNED_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] mul_result
);

    localparam int C_W   = A_W + B_W;
    localparam int CNT_W = cnt_width(B_W);

    state_t           state_q, state_d;
    logic [C_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [C_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [C_W-1:0]   res_q, res_d;
    logic             sgn_q, sgn_d;
    logic             sgn_in;
    logic             last;
    logic [C_W-1:0]   step_sum;

`ifdef MUL_SIGNED_EN
    assign sgn_in = is_signed;
`else
    assign sgn_in = 1'b0;
`endif

    assign last       = cnt_q == CNT_W'(B_W - 1);
    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign mul_result = res_q;

    mul_addsub #(.W(C_W)) u_addsub (
        .acc  (acc_q),
        .opnd (b_q[0] ? a_q : '0),
        .sub  (sgn_q & last),
        .sum  (step_sum)
    );

    // next state: latch operands in IDLE, one bit per CALC cycle, publish result on the last step
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sgn_d   = sgn_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CALC;
                a_d     = {{B_W{sgn_in & mul_a[A_W-1]}}, mul_a};
                b_d     = mul_b;
                acc_d   = '0;
                cnt_d   = '0;
                sgn_d   = sgn_in;
            end
            CALC: begin
                acc_d = step_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = DONE;
                    res_d   = step_sum;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared immediately by reset
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sgn_q   <= sgn_d;
        end
    end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter A_W, default 8, multiplicand width (>=2).
REQ-002 SHALL have parameter B_W, default 8, multiplier width (>=2) and iteration count.
REQ-003 SHALL derive C_W = A_W + B_W internally; C_W is not overridable.
REQ-004 sysclk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  block able to accept operands.
REQ-008 mul_a  input  A_W  multiplicand.
REQ-009 mul_b  input  B_W  multiplier.
REQ-010 is_signed  input  1  two's-complement mode for this operation; present only with MUL_SIGNED_EN.
REQ-011 out_valid  output  1  mul_result holds a finished product.
REQ-012 out_ready  input  1  consumer accepts the product.
REQ-013 mul_result  output  C_W  product, registered.

Function
REQ-014 FSM SHALL have states IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid && in_ready, latch mul_a, mul_b and is_signed, clear accumulator and iteration counter, then go to CALC.
REQ-016 CALC: each cycle, inspect the current multiplier LSB; if 1, add the shifted multiplicand to the accumulator; shift; increment the counter.
REQ-017 CALC SHALL last exactly B_W cycles, then go to DONE; there is no early exit for zero or small operands.
REQ-018 out_valid SHALL assert on the B_W-th rising edge after the accepting edge; fixed latency B_W, independent of operand values.
REQ-019 DONE: mul_result and out_valid SHALL hold stable while out_ready=0.
REQ-020 DONE with out_ready=1: go to IDLE on that edge; in_ready high in the following cycle; maximum throughput is one product per B_W+2 cycles.
REQ-021 in_valid, mul_a, mul_b and is_signed SHALL be ignored outside IDLE; an operand change mid-operation does not affect the result.
REQ-022 Unsigned result SHALL be the exact product mod 2^C_W; it never overflows.
REQ-023 mul_result SHALL update only on the CALC->DONE transition; otherwise it holds its last value.

Reset
REQ-024 rst=0 SHALL force state IDLE, accumulator 0, counter 0, mul_result 0 and out_valid 0 immediately, without waiting for sysclk.
REQ-025 Reset during CALC or DONE SHALL abort the operation; no partial result is ever presented.
REQ-026 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 Macro MUL_SIGNED_EN defined: is_signed port exists.
- is_signed=1: operands are two's complement; multiplicand sign-extended to C_W; the final (MSB) multiplier step subtracts instead of adds.
- Result is the exact signed product in C_W bits.
REQ-028 Macro MUL_SIGNED_EN undefined: no is_signed port; unsigned only; no subtract path synthesised.

Structure
REQ-029 Shared package mul_pkg SHALL hold the state typedef (IDLE=0, CALC=1, DONE=2, 2 bits) and a counter-width constant function (clog2 of B_W+1).
REQ-030 One combinational sub-module, mul_addsub, SHALL perform the C_W-wide add/subtract step; mul_iter instantiates it once.

Verification (A_W=B_W=8)
REQ-031 Accept 13 x 11, out_ready=1 -> mul_result=143, out_valid exactly 8 cycles after accept, in_ready back after 1 more cycle.
REQ-032 Accept 255 x 255, then 0 x 200 -> 65025 then 0, both at fixed latency 8.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> result and out_valid stable, in_ready=0, no new operation accepted.
REQ-034 Pulse rst low 3 cycles into CALC -> all outputs 0 immediately, in_ready=1 after release, next 6 x 7 gives 42.
REQ-035 MUL_SIGNED_EN, is_signed=1 -> -3 x 5 = 16'hFFF1 and -128 x -128 = 16'h4000; is_signed=0, 8'hFD x 5 -> 1265.
